avalon_read_master: RTL and testbench

AVALON_READ_MASTER -- requirements
Module: avalon_read_master

---
 rtl/avalon_read_master.sv | 132 +++++++++++++
 tb/tb_avalon_read_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_read_master.sv
// Avalon-MM pipelined read master: streams a block of words into a show-ahead FIFO.
// Reads are only issued while the FIFO has room for every word already in flight.
module avalon_read_master #(
    parameter int ADDRESSWIDTH    = 28,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int FIFODEPTH       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_read_base,
    input  logic [ADDRESSWIDTH-1:0]    control_read_length,
    input  logic                       control_go,
    output logic                       control_done,
    input  logic                       user_read_buffer,
    output logic [DATAWIDTH-1:0]       user_buffer_output_data,
    output logic                       user_data_available,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_read,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    input  logic [DATAWIDTH-1:0]       master_readdata,
    input  logic                       master_readdatavalid,
    input  logic                       master_waitrequest
);

    localparam int PTR_W = $clog2(FIFODEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [ADDRESSWIDTH-1:0] STEP     = ADDRESSWIDTH'(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0] LEN_MASK = ~(STEP - ADDRESSWIDTH'(1));

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [ADDRESSWIDTH-1:0] remaining_q, remaining_d;
    logic                    fixed_q, fixed_d;
    logic [CNT_W-1:0]        outstanding_q, outstanding_d;
    logic [CNT_W-1:0]        fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [DATAWIDTH-1:0]    fifo_mem [FIFODEPTH];

    logic             read_ok;
    logic             accept;
    logic             push;
    logic             pop;
    logic [SUM_W-1:0] in_flight;

    // Words buffered plus words requested must never exceed the FIFO, so a push can never overflow.
    assign in_flight = SUM_W'(fifo_count_q) + SUM_W'(outstanding_q);
    assign read_ok   = (state_q == ISSUE) && (remaining_q != '0) && (in_flight < SUM_W'(FIFODEPTH));
    assign accept    = read_ok && !master_waitrequest;
    assign push      = master_readdatavalid && (outstanding_q != '0);
    assign pop       = user_read_buffer && (fifo_count_q != '0);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        fixed_d       = fixed_q;
        outstanding_d = outstanding_q;
        fifo_count_d  = fifo_count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        case (state_q)
            IDLE: begin
                if (control_go) begin
                    addr_d      = control_read_base;
                    remaining_d = control_read_length & LEN_MASK;
                    fixed_d     = control_fixed_location;
                    if ((control_read_length & LEN_MASK) != '0) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    remaining_d = remaining_q - STEP;
                    if (!fixed_q) addr_d = addr_q + STEP;
                    if (remaining_q == STEP) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept && !push) outstanding_d = outstanding_q + CNT_W'(1);
        else if (!accept && push) outstanding_d = outstanding_q - CNT_W'(1);

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop) fifo_count_d = fifo_count_q + CNT_W'(1);
        else if (!push && pop) fifo_count_d = fifo_count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            fixed_q       <= 1'b0;
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            fixed_q       <= fixed_d;
            outstanding_q <= outstanding_d;
            fifo_count_q  <= fifo_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= master_readdata;
    end

    assign control_done            = (state_q == IDLE);
    assign master_address          = addr_q;
    assign master_read             = read_ok;
    assign master_byteenable       = '1;
    assign user_data_available     = (fifo_count_q != '0);
    assign user_buffer_output_data = user_data_available ? fifo_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_avalon_read_master.sv
// Bench for avalon_read_master: a cycle-stepped Avalon slave plus a transaction-level
// model (word counts, expected address, FIFO contents as a queue) checked every cycle.
module tb_avalon_read_master;

    localparam int AW    = 28;
    localparam int DW    = 32;
    localparam int BEW   = 4;
    localparam int DEPTH = 8;

    logic           clk;
    logic           reset;
    logic           control_fixed_location;
    logic [AW-1:0]  control_read_base;
    logic [AW-1:0]  control_read_length;
    logic           control_go;
    logic           control_done;
    logic           user_read_buffer;
    logic [DW-1:0]  user_buffer_output_data;
    logic           user_data_available;
    logic [AW-1:0]  master_address;
    logic           master_read;
    logic [BEW-1:0] master_byteenable;
    logic [DW-1:0]  master_readdata;
    logic           master_readdatavalid;
    logic           master_waitrequest;

    avalon_read_master #(
        .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .BYTEENABLEWIDTH(BEW), .FIFODEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .control_fixed_location(control_fixed_location),
        .control_read_base(control_read_base),
        .control_read_length(control_read_length),
        .control_go(control_go), .control_done(control_done),
        .user_read_buffer(user_read_buffer),
        .user_buffer_output_data(user_buffer_output_data),
        .user_data_available(user_data_available),
        .master_address(master_address), .master_read(master_read),
        .master_byteenable(master_byteenable),
        .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .master_waitrequest(master_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Transaction-level model
    bit            busy = 0;
    int            total = 0;
    int            acc_cnt = 0;
    logic [AW-1:0] exp_addr = '0;
    bit            fixed_m = 0;
    logic [DW-1:0] buf_q[$];

    // Slave response pipeline: ready cycle, data, and whether the request was cut off by reset
    int unsigned   pend_rdy[$];
    logic [DW-1:0] pend_data[$];
    bit            pend_stray[$];
    int unsigned   cyc = 0;
    int unsigned   last_rdy = 0;

    int            lat_min = 0, lat_max = 3;
    int            p_wait = 0, p_pop = 0;
    int            stall_left = 0;
    bit            force_en = 0;
    logic [DW-1:0] force_data = '0;
    bit            stalled_prev = 0;
    logic [AW-1:0] stall_addr = '0;
    int            mon_acc = 0, mon_pop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int outst();
        int n = 0;
        foreach (pend_stray[i]) if (!pend_stray[i]) n++;
        return n;
    endfunction

    task automatic tick();
        logic          exp_rd, acc_now, rdv_now, pop_now;
        bit            busy_pre;
        int            o;
        int unsigned   rdy;
        logic [DW-1:0] d;
        logic [AW-1:0] t;
        bit            st;
        o = outst();
        exp_rd = busy && (acc_cnt < total) && ((buf_q.size() + o) < DEPTH);
        chk("done", control_done, !busy);
        chk("master_read", master_read, exp_rd);
        if (exp_rd) chk("address", master_address, exp_addr);
        if (stalled_prev) begin
            chk("stall_read_held", master_read, 1'b1);
            chk("stall_addr_held", master_address, stall_addr);
        end
        chk("avail", user_data_available, buf_q.size() != 0);
        if (buf_q.size() != 0) chk("head_data", user_buffer_output_data, buf_q[0]);
        stalled_prev = master_read && master_waitrequest && !reset;
        stall_addr   = master_address;
        acc_now  = master_read && !master_waitrequest && !reset;
        rdv_now  = master_readdatavalid;
        pop_now  = user_read_buffer && (buf_q.size() != 0);
        busy_pre = busy;
        if (acc_now) mon_acc++;
        if (user_read_buffer && user_data_available && !reset) mon_pop++;
        @(posedge clk);
        cyc++;
        if (reset) begin
            foreach (pend_stray[i]) pend_stray[i] = 1;
            buf_q.delete();
            busy = 0; total = 0; acc_cnt = 0; exp_addr = '0; fixed_m = 0;
        end else begin
            if (busy && acc_cnt == total && o == 0) busy = 0;
            if (pop_now) void'(buf_q.pop_front());
            if (rdv_now && pend_rdy.size() > 0) begin
                void'(pend_rdy.pop_front());
                d  = pend_data.pop_front();
                st = pend_stray.pop_front();
                if (!st) buf_q.push_back(d);
            end
            if (acc_now) begin
                d = force_en ? force_data : $urandom;
                rdy = cyc + $urandom_range(lat_max, lat_min);
                if (rdy < last_rdy) rdy = last_rdy;
                last_rdy = rdy;
                pend_rdy.push_back(rdy);
                pend_data.push_back(d);
                pend_stray.push_back(1'b0);
                acc_cnt++;
                if (!fixed_m) exp_addr = exp_addr + AW'(BEW);
            end
            if (control_go && !busy_pre) begin
                t = control_read_length & ~AW'(BEW - 1);
                if (t != '0) begin
                    busy = 1; total = int'(t) / BEW; acc_cnt = 0;
                    exp_addr = control_read_base; fixed_m = control_fixed_location;
                end
            end
        end
        @(negedge clk);
        if (pend_rdy.size() > 0 && pend_rdy[0] <= cyc && !reset) begin
            master_readdatavalid = 1'b1;
            master_readdata      = pend_data[0];
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = $urandom;
        end
        if (stall_left > 0 && master_read) begin
            master_waitrequest = 1'b1;
            stall_left--;
        end else begin
            master_waitrequest = ($urandom_range(99) < p_wait);
        end
        user_read_buffer = ($urandom_range(99) < p_pop);
    endtask

    task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic fixed);
        control_read_base      = base;
        control_read_length    = len;
        control_fixed_location = fixed;
        control_go             = 1'b1;
        tick();
        control_go = 1'b0;
    endtask

    task automatic run_idle(input int budget, input string tag);
        int n = 0;
        while ((busy || pend_rdy.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, n < budget, 1'b1);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        p_pop = 100;
        while ((busy || pend_rdy.size() > 0 || buf_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, n < budget, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        master_waitrequest = 1'b1;
        master_readdatavalid = 1'b0;
        tick();
        reset = 1'b0;
        master_waitrequest = 1'b1;
        master_readdatavalid = 1'b0;
    endtask

    initial begin
        int a0, p0, n;
        reset = 1'b1;
        control_fixed_location = 1'b0;
        control_read_base = '0;
        control_read_length = '0;
        control_go = 1'b0;
        user_read_buffer = 1'b0;
        master_readdata = '0;
        master_readdatavalid = 1'b0;
        master_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", control_done, 1'b1);
        chk("rst_read", master_read, 1'b0);
        chk("rst_addr", master_address, '0);
        chk("rst_avail", user_data_available, 1'b0);
        chk("rst_data", user_buffer_output_data, '0);
        chk("rst_byteenable", master_byteenable, 4'hF);
        reset = 1'b0;

        // Single word read with fixed latency and known data
        lat_min = 1; lat_max = 1; force_en = 1; force_data = 32'hAAAA0000;
        a0 = mon_acc;
        start(28'h8000000, 28'd4, 1'b0);
        chk("single_busy", control_done, 1'b0);
        run_idle(50, "single_timeout");
        tick();
        chk("single_reads", mon_acc - a0, 1);
        chk("single_done", control_done, 1'b1);
        chk("single_avail", user_data_available, 1'b1);
        chk("single_data", user_buffer_output_data, 32'hAAAA0000);
        user_read_buffer = 1'b1;
        tick();
        chk("single_popped", user_data_available, 1'b0);
        force_en = 0;

        // 24-word block with no pops: stops at FIFO depth, then completes as data is consumed
        lat_min = 0; lat_max = 3; p_wait = 0; p_pop = 0;
        a0 = mon_acc; p0 = mon_pop;
        start(28'h8000004, 28'd96, 1'b0);
        repeat (40) tick();
        chk("full_reads", mon_acc - a0, 8);
        chk("full_read_low", master_read, 1'b0);
        chk("full_avail", user_data_available, 1'b1);
        drain(400, "block_timeout");
        chk("block_reads", mon_acc - a0, 24);
        chk("block_pops", mon_pop - p0, 24);
        chk("block_done", control_done, 1'b1);

        // Fixed location with a 3-cycle stall on the first read
        a0 = mon_acc; stall_left = 3; p_pop = 100;
        start(28'h0000100, 28'd12, 1'b1);
        run_idle(100, "fixed_timeout");
        chk("fixed_reads", mon_acc - a0, 3);
        chk("fixed_stall_used", stall_left, 0);

        // Zero / sub-word lengths, then a go during a transfer
        a0 = mon_acc;
        start(28'h0000300, 28'd0, 1'b0);
        repeat (4) tick();
        start(28'h0000300, 28'd3, 1'b0);
        repeat (4) tick();
        chk("short_reads", mon_acc - a0, 0);
        chk("short_done", control_done, 1'b1);
        start(28'h0000200, 28'd32, 1'b0);
        repeat (2) tick();
        start(28'h0000900, 28'd16, 1'b0);
        run_idle(200, "ignore_go_timeout");
        chk("ignore_go_reads", mon_acc - a0, 8);

        // Address wrap at the top of the address space
        a0 = mon_acc;
        start(28'hFFFFFF8, 28'd16, 1'b0);
        run_idle(200, "wrap_timeout");
        chk("wrap_reads", mon_acc - a0, 4);

        // Randomized transfers with stalls, variable latency and partial consumption
        p_wait = 30; lat_min = 0; lat_max = 3;
        for (int k = 0; k < 12; k++) begin
            p_pop = $urandom_range(80, 20);
            start(AW'($urandom), AW'($urandom_range(80, 0)), $urandom_range(1, 0) == 1);
            n = $urandom_range(60, 0);
            repeat (n) tick();
        end
        drain(2000, "random_timeout");
        chk("random_done", control_done, 1'b1);

        // Reset with two reads in flight; their late responses must be dropped
        p_wait = 0; p_pop = 0; lat_min = 8; lat_max = 8;
        a0 = mon_acc;
        start(28'h0000040, 28'd64, 1'b0);
        n = 0;
        while (outst() < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("abort_two_out", mon_acc - a0, 2);
        do_reset();
        repeat (15) tick();
        chk("abort_done", control_done, 1'b1);
        chk("abort_avail", user_data_available, 1'b0);
        chk("abort_read", master_read, 1'b0);
        chk("abort_no_more_reads", mon_acc - a0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
